bp_lce_req_arbiter: RTL and testbench

//  Shares one LCE-to-CCE request network port between num_src_p LCE request handlers,
//  e.g. I$ and D$ LCEs behind one coherence NoC link.

---
 rtl/bp_me_pkg.sv | 29 ++
 rtl/bp_me_credit_counter_async.sv | 50 +++++
 rtl/bp_lce_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_bp_lce_req_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// -----------------------------------------------------------------------------
// bp_me_pkg
//  Shared types and sizing helpers for the LCE request arbitration slice.
//  Contents:
//   bp_lce_req_arb_state_e  grant FSM state (idle / locked on a stalled grant)
//   lce_req_msg_width_lp    default LCE request message width
//   coh_noc_max_credits_p   default outstanding-request limit per source
//   safe_clog2()            index width, never less than 1
//   safe_width()            bits needed to hold the value x itself
// -----------------------------------------------------------------------------
package bp_me_pkg;

   typedef enum logic [0:0] {
      e_idle,
      e_locked
   } bp_lce_req_arb_state_e;

   localparam int unsigned lce_req_msg_width_lp  = 32;
   localparam int unsigned coh_noc_max_credits_p = 8;

   function automatic int unsigned safe_clog2(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   function automatic int unsigned safe_width(input int unsigned x);
      return safe_clog2(x + 1);
   endfunction

endpackage

// File: rtl/bp_me_credit_counter_async.sv
// -----------------------------------------------------------------------------
// bp_me_credit_counter_async
//  Outstanding-request counter for one source, range 0..max_val_p.
//  Ports:
//   clk_i      in   clock
//   reset_n_i  in   asynchronous active-low reset (count -> 0)
//   up_i       in   one request issued
//   down_i     in   one request completed
//   full_o     out  count == max_val_p
//   empty_o    out  count == 0
//  Simultaneous up/down leaves the count unchanged; a lone down at zero holds.
// -----------------------------------------------------------------------------
module bp_me_credit_counter_async
   import bp_me_pkg::*;
#(
   parameter  int unsigned max_val_p = 8,
   localparam int unsigned width_lp  = safe_width(max_val_p)
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic up_i,
   input  logic down_i,
   output logic full_o,
   output logic empty_o
);

   logic [width_lp-1:0] r_count;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_count <= '0;
      end else if (up_i && !down_i) begin
         r_count <= r_count + width_lp'(1);
      end else if (down_i && !up_i && (r_count != '0)) begin
         r_count <= r_count - width_lp'(1);
      end
   end

   assign full_o  = (r_count == width_lp'(max_val_p));
   assign empty_o = (r_count == '0);

   a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (down_i && !up_i) |-> (r_count != '0))
      else $error("credit counter: completion with no outstanding request");

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (up_i && !down_i) |-> !full_o)
      else $error("credit counter: issue beyond credit limit");

endmodule

// File: rtl/bp_lce_req_arbiter.sv
// -----------------------------------------------------------------------------
// bp_lce_req_arbiter
//  Shares one LCE-to-CCE request port between num_src_p request handlers.
//  Round-robin among sources that are valid and below their credit limit;
//  a grant presented while the network stalls is locked until consumed or
//  until the locked source drops valid.
//  Ports:
//   clk_i               in   clock
//   reset_n_i           in   asynchronous active-low reset
//   src_req_i           in   num_src_p packed request messages
//   src_req_v_i         in   per-source request valid
//   src_req_yumi_o      out  per-source consume strobe (one-hot or zero)
//   src_credits_full_o  out  per-source outstanding count == credits_p
//   src_credits_empty_o out  per-source outstanding count == 0
//   complete_v_i        in   one request completed
//   complete_src_i      in   source index of the completed request
//   lce_req_o           out  granted message, zero when nothing is granted
//   lce_req_v_o         out  output valid
//   lce_req_yumi_i      in   network consumed lce_req_o this cycle
// -----------------------------------------------------------------------------
module bp_lce_req_arbiter
   import bp_me_pkg::*;
#(
   parameter  int unsigned num_src_p   = 2,
   parameter  int unsigned msg_width_p = lce_req_msg_width_lp,
   parameter  int unsigned credits_p   = coh_noc_max_credits_p,
   localparam int unsigned lg_src_lp   = safe_clog2(num_src_p)
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_src_p*msg_width_p-1:0] src_req_i,
   input  logic [num_src_p-1:0]             src_req_v_i,
   output logic [num_src_p-1:0]             src_req_yumi_o,
   output logic [num_src_p-1:0]             src_credits_full_o,
   output logic [num_src_p-1:0]             src_credits_empty_o,
   input  logic                             complete_v_i,
   input  logic [lg_src_lp-1:0]             complete_src_i,
   output logic [msg_width_p-1:0]           lce_req_o,
   output logic                             lce_req_v_o,
   input  logic                             lce_req_yumi_i
);

   bp_lce_req_arb_state_e r_state;
   logic [lg_src_lp-1:0]  r_rr_ptr;
   logic [lg_src_lp-1:0]  r_grant;

   logic [msg_width_p-1:0] w_msg [num_src_p];
   logic [num_src_p-1:0]   w_elig;
   logic [num_src_p-1:0]   w_down;
   logic [lg_src_lp:0]     w_scan;
   logic [lg_src_lp-1:0]   w_rr_grant;
   logic                   w_rr_found;
   logic [lg_src_lp-1:0]   w_sel;
   logic [lg_src_lp-1:0]   w_sel_inc;
   logic                   w_v;
   logic                   w_take;

   for (genvar gi = 0; gi < num_src_p; gi++) begin : g_src
      assign w_msg[gi]  = src_req_i[gi*msg_width_p +: msg_width_p];
      // Out-of-range completion indices never match any source, so they drop.
      assign w_down[gi] = complete_v_i && (complete_src_i == lg_src_lp'(gi));

      bp_me_credit_counter_async #(
         .max_val_p(credits_p)
      ) u_cnt (
         .clk_i    (clk_i),
         .reset_n_i(reset_n_i),
         .up_i     (src_req_yumi_o[gi]),
         .down_i   (w_down[gi]),
         .full_o   (src_credits_full_o[gi]),
         .empty_o  (src_credits_empty_o[gi])
      );
   end

   assign w_elig = src_req_v_i & ~src_credits_full_o;

   // Scan from rr_ptr upward, wrapping modulo num_src_p; first eligible wins.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_grant = '0;
      w_scan     = '0;
      for (int unsigned k = 0; k < num_src_p; k++) begin
         w_scan = {1'b0, r_rr_ptr} + (lg_src_lp+1)'(k);
         if (w_scan >= (lg_src_lp+1)'(num_src_p)) begin
            w_scan = w_scan - (lg_src_lp+1)'(num_src_p);
         end
         if (!w_rr_found && w_elig[w_scan[lg_src_lp-1:0]]) begin
            w_rr_found = 1'b1;
            w_rr_grant = w_scan[lg_src_lp-1:0];
         end
      end
   end

   // Locked grants bypass the credit mask: credit was checked when locking.
   // Outputs are forced quiet while reset is held.
   always_comb begin
      w_sel = (r_state == e_locked) ? r_grant : w_rr_grant;
      w_v   = reset_n_i && ((r_state == e_locked) ? src_req_v_i[r_grant] : w_rr_found);
   end

   assign w_take    = w_v && lce_req_yumi_i;
   assign w_sel_inc = (w_sel == lg_src_lp'(num_src_p-1)) ? '0 : w_sel + lg_src_lp'(1);

   assign lce_req_v_o    = w_v;
   assign lce_req_o      = w_v ? w_msg[w_sel] : '0;
   assign src_req_yumi_o = w_take ? (num_src_p'(1) << w_sel) : '0;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= e_idle;
         r_rr_ptr <= '0;
         r_grant  <= '0;
      end else begin
         case (r_state)
            e_idle: begin
               if (w_take) begin
                  r_rr_ptr <= w_sel_inc;
               end else if (w_v) begin
                  r_grant <= w_sel;
                  r_state <= e_locked;
               end
            end
            e_locked: begin
               if (w_take) begin
                  r_rr_ptr <= w_sel_inc;
                  r_state  <= e_idle;
               end else if (!w_v) begin
                  r_state <= e_idle;
               end
            end
         endcase
      end
   end

   a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      lce_req_yumi_i |-> lce_req_v_o)
      else $error("lce_req_yumi_i asserted without lce_req_v_o");

   a_src_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      complete_v_i |-> (32'(complete_src_i) < num_src_p))
      else $error("complete_src_i out of range");

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
module tb_bp_lce_req_arbiter;

   localparam int unsigned NS = 2;
   localparam int unsigned MW = 16;
   localparam int unsigned CR = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NS*MW-1:0]  src_req;
   logic [NS-1:0]     src_v;
   logic [NS-1:0]     yumi_o;
   logic [NS-1:0]     full_o;
   logic [NS-1:0]     empty_o;
   logic              cv;
   logic [0:0]        cs;
   logic [MW-1:0]     req_o;
   logic              v_o;
   logic              yumi_i;

   always #5 clk = ~clk;

   bp_lce_req_arbiter #(
      .num_src_p  (NS),
      .msg_width_p(MW),
      .credits_p  (CR)
   ) dut (
      .clk_i              (clk),
      .reset_n_i          (rst_n),
      .src_req_i          (src_req),
      .src_req_v_i        (src_v),
      .src_req_yumi_o     (yumi_o),
      .src_credits_full_o (full_o),
      .src_credits_empty_o(empty_o),
      .complete_v_i       (cv),
      .complete_src_i     (cs),
      .lce_req_o          (req_o),
      .lce_req_v_o        (v_o),
      .lce_req_yumi_i     (yumi_i)
   );

   int total = 0;
   int bad   = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: who holds the port, where the round-robin resumes,
   // and how many requests each source has in flight.
   bit          m_lock;
   int unsigned m_lk;
   int unsigned m_rr;
   int unsigned m_cnt [NS];

   function automatic void model_out(output bit v, output int unsigned sel);
      v   = 1'b0;
      sel = 0;
      if (rst_n !== 1'b1) return;
      if (m_lock) begin
         sel = m_lk;
         v   = src_v[m_lk];
      end else begin
         for (int k = 0; k < NS; k++) begin
            int unsigned s;
            s = (m_rr + k) % NS;
            if (src_v[s] && m_cnt[s] < CR) begin
               v   = 1'b1;
               sel = s;
               break;
            end
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit          v;
      int unsigned sel;
      int unsigned nc [NS];
      if (!rst_n) begin
         m_lock <= 1'b0;
         m_lk   <= 0;
         m_rr   <= 0;
         for (int i = 0; i < NS; i++) m_cnt[i] <= 0;
      end else begin
         model_out(v, sel);
         for (int i = 0; i < NS; i++) nc[i] = m_cnt[i];
         if (v && yumi_i) begin
            nc[sel] = nc[sel] + 1;
            m_rr   <= (sel + 1) % NS;
            m_lock <= 1'b0;
         end else if (v) begin
            m_lock <= 1'b1;
            m_lk   <= sel;
         end else begin
            m_lock <= 1'b0;
         end
         if (cv && cs < NS && nc[cs] > 0) nc[cs] = nc[cs] - 1;
         for (int i = 0; i < NS; i++) m_cnt[i] <= nc[i];
      end
   end

   bit chk_en = 1'b0;

   always @(negedge clk) begin
      bit              ev;
      int unsigned     es;
      logic [MW-1:0]   em;
      logic [NS-1:0]   ey, ef, ee;
      if (chk_en) begin
         model_out(ev, es);
         em = ev ? src_req[es*MW +: MW] : '0;
         ey = (ev && yumi_i) ? NS'(1) << es : '0;
         for (int i = 0; i < NS; i++) begin
            ef[i] = (rst_n === 1'b1) ? (m_cnt[i] == CR) : 1'b0;
            ee[i] = (rst_n === 1'b1) ? (m_cnt[i] == 0)  : 1'b1;
         end
         chk("model v_o",   v_o,     ev);
         chk("model msg",   req_o,   em);
         chk("model yumi",  yumi_o,  ey);
         chk("model full",  full_o,  ef);
         chk("model empty", empty_o, ee);
      end
   end

   task automatic drive(input logic [NS-1:0] v, input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                        input logic y, input logic c_v, input logic c_s);
      src_v   = v;
      src_req = {m1, m0};
      yumi_i  = y;
      cv      = c_v;
      cs      = c_s;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
      next();
      next();
      rst_n = 1'b1;
   endtask

   localparam logic [MW-1:0] M0 = 16'h1234;
   localparam logic [MW-1:0] M1 = 16'hABCD;

   initial begin
      rst_n = 1'b0;
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;

      // reset state, inputs active during reset must not leak out
      next();
      drive(2'b11, M0, M1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst v_o", v_o, 1'b0);
      chk("rst msg", req_o, '0);
      chk("rst yumi", yumi_o, 2'b00);
      chk("rst empty", empty_o, 2'b11);
      chk("rst full", full_o, 2'b00);
      do_reset();

      // 2: alternating grants with continuous consume
      for (int c = 0; c < 4; c++) begin
         drive(2'b11, 16'hA000 + 16'(c), 16'hB000 + 16'(c), 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         chk("t2 yumi", yumi_o, (c % 2 == 0) ? 2'b01 : 2'b10);
         chk("t2 msg", req_o, (c % 2 == 0) ? 16'hA000 + 16'(c) : 16'hB000 + 16'(c));
         next();
      end
      drive('0, '0, '0, 1'b0, 1'b1, 1'b0); @(negedge clk);
      chk("t2 empty after 4", empty_o, 2'b00);
      next();
      drive('0, '0, '0, 1'b0, 1'b1, 1'b0); @(negedge clk);
      chk("t2 empty src0 1 left", empty_o, 2'b00);
      next();
      drive('0, '0, '0, 1'b0, 1'b1, 1'b1); @(negedge clk);
      chk("t2 empty src0 drained", empty_o, 2'b01);
      next();
      drive('0, '0, '0, 1'b0, 1'b1, 1'b1); next();
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0); @(negedge clk);
      chk("t2 empty all drained", empty_o, 2'b11);
      next();

      // 3: grant lock while stalled
      do_reset();
      drive(2'b01, M0, M1, 1'b0, 1'b0, 1'b0); @(negedge clk);
      chk("t3 v c0", v_o, 1'b1);
      chk("t3 msg c0", req_o, M0);
      next();
      for (int c = 1; c < 3; c++) begin
         drive(2'b11, M0, M1, 1'b0, 1'b0, 1'b0); @(negedge clk);
         chk("t3 msg held", req_o, M0);
         next();
      end
      drive(2'b11, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk);
      chk("t3 yumi src0", yumi_o, 2'b01);
      chk("t3 msg at yumi", req_o, M0);
      next();
      drive(2'b11, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk);
      chk("t3 next grant src1", yumi_o, 2'b10);
      chk("t3 next msg", req_o, M1);
      next();

      // 4: credit exhaustion masks src1, one completion unmasks it
      do_reset();
      for (int c = 0; c < 8; c++) begin
         drive(2'b10, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk);
         chk("t4 fill yumi", yumi_o, 2'b10);
         next();
      end
      drive(2'b11, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk);
      chk("t4 full", full_o, 2'b10);
      chk("t4 masked yumi", yumi_o, 2'b01);
      chk("t4 masked msg", req_o, M0);
      next();
      drive(2'b10, M0, M1, 1'b0, 1'b1, 1'b1); @(negedge clk);
      chk("t4 masked v_o", v_o, 1'b0);
      next();
      drive(2'b11, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk);
      chk("t4 full cleared", full_o, 2'b00);
      chk("t4 src1 regranted", yumi_o, 2'b10);
      next();

      // 5: same-cycle issue and completion leaves count alone
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(2'b01, M0, M1, 1'b1, 1'b0, 1'b0); next();
      end
      drive(2'b01, M0, M1, 1'b1, 1'b1, 1'b0); next();
      for (int c = 0; c < 3; c++) begin
         drive('0, '0, '0, 1'b0, 1'b1, 1'b0); @(negedge clk);
         chk("t5 not yet empty", empty_o[0], 1'b0);
         next();
      end
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0); @(negedge clk);
      chk("t5 empty after 3", empty_o[0], 1'b1);
      next();

      // 6: locked source drops valid
      do_reset();
      drive(2'b10, M0, M1, 1'b0, 1'b0, 1'b0); @(negedge clk);
      chk("t6 lock msg", req_o, M1);
      next();
      drive(2'b01, M0, M1, 1'b0, 1'b0, 1'b0); @(negedge clk);
      chk("t6 dropped v_o", v_o, 1'b0);
      chk("t6 dropped msg", req_o, '0);
      next();
      drive(2'b01, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk);
      chk("t6 src0 granted", yumi_o, 2'b01);
      chk("t6 src0 msg", req_o, M0);
      next();

      // 1: asynchronous reset in the middle of a lock
      do_reset();
      drive(2'b10, M0, M1, 1'b1, 1'b0, 1'b0); @(negedge clk); next();
      drive(2'b01, M0, M1, 1'b0, 1'b0, 1'b0); @(negedge clk);
      chk("t1 pre empty", empty_o, 2'b01);
      next();
      #1 rst_n = 1'b0;
      #1;
      chk("t1 async v_o", v_o, 1'b0);
      chk("t1 async yumi", yumi_o, 2'b00);
      chk("t1 async msg", req_o, '0);
      chk("t1 async empty", empty_o, 2'b11);
      next();
      rst_n = 1'b1;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit          ev;
         int unsigned es;
         logic [0:0]  s;
         src_v   = NS'($urandom);
         src_req = {16'($urandom), 16'($urandom)};
         model_out(ev, es);
         yumi_i  = ev && ($urandom_range(0, 3) != 0);
         s       = 1'($urandom_range(0, 1));
         cs      = s;
         cv      = (m_cnt[s] > 0) && ($urandom_range(0, 2) == 0);
         next();
      end

      drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
      next();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
